booth_mult_seq: RTL

Parametrised sequential radix-2 Booth multiplier with an integrated controller and a start/done handshake. Multiplies two W-bit operands in W iteration cycles (W+1 with unsigned support compiled in) and returns a registered 2W-bit product. Successor to the fixed 5-bit Booth datapath plus external controller pair; it drops in wherever a multi-cycle multiply is issued by a top-level FSM.

---
 rtl/booth_mult_seq.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/booth_mult_seq.sv
`default_nettype none
// ============================================================================
// Module   : booth_mult_seq
// Brief    : Sequential radix-2 Booth multiplier with start/done handshake.
//            Define BOOTH_UNSIGNED_EN to add the is_signed port (N = W+1).
// Revision : 1.0 - initial release
// ============================================================================
module booth_mult_seq #(
    parameter int W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [W-1:0]     x,
    input  logic [W-1:0]     y,
`ifdef BOOTH_UNSIGNED_EN
    input  logic             is_signed,
`endif
    output logic             busy,
    output logic             done,
    output logic [2*W-1:0]   result
);

`ifdef BOOTH_UNSIGNED_EN
    localparam int N = W + 1;
`else
    localparam int N = W;
`endif
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [N:0]        a_q, a_d;
    logic [N-1:0]      x_q, x_d;
    logic [N:0]        y_q, y_d;
    logic              ff_q, ff_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*W-1:0]    res_q, res_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              w_sign;
    logic [N-1:0]      w_x_ext;
    logic [N:0]        w_y_ext;
    logic [N:0]        w_acc;

`ifdef BOOTH_UNSIGNED_EN
    assign w_sign = is_signed;
`else
    assign w_sign = 1'b1;
`endif

    // Upper bits replicate the operand MSB only for signed operands.
    always_comb begin
        w_x_ext        = '0;
        w_y_ext        = '0;
        w_x_ext[W-1:0] = x;
        w_y_ext[W-1:0] = y;
        for (int i = W; i < N; i++) begin
            w_x_ext[i] = w_sign & x[W-1];
        end
        for (int i = W; i <= N; i++) begin
            w_y_ext[i] = w_sign & y[W-1];
        end
    end

    always_comb begin
        case ({x_q[0], ff_q})
            2'b10:   w_acc = a_q - y_q;
            2'b01:   w_acc = a_q + y_q;
            default: w_acc = a_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        x_d     = x_q;
        y_d     = y_q;
        ff_d    = ff_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = '0;
                    ff_d    = 1'b0;
                    cnt_d   = '0;
                    x_d     = w_x_ext;
                    y_d     = w_y_ext;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = {w_acc[N], w_acc[N:1]};
                x_d   = {w_acc[0], x_q[N-1:1]};
                ff_d  = x_q[0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                    // Low 2W bits of the shifted {A,X} hold the product.
                    res_d   = {a_d[2*W-N-1:0], x_d};
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            ff_q    <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ff_q    <= ff_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = res_q;

endmodule
`default_nettype wire
